// File: rtl/window_generator_7x7_if.sv
// ---------------------------------------------------------------------------
// window_generator_7x7_if
//
// Purpose: bundles the pixel-stream input and the window output of
// window_generator_7x7 so that producer and consumer attach through one
// port.
//
// Signals:
//   pix_in     PIX_BIT                raster pixel
//   pix_valid  1                      pix_in is valid this cycle (no backpressure)
//   sof        1                      start of frame, qualified by pix_valid
//   p          PIX_BIT*MASK_WIDTH**2  window; slice r*MASK_WIDTH+c, r=0 top, c=0 left
//   win_valid  1                      p holds a complete window this cycle
//   frame_done 1                      one-cycle pulse after the last frame pixel
//   overflow   1                      sticky: pixel arrived after frame completion
//
// Modports:
//   master  pixel source / window consumer side
//   slave   window generator side
// ---------------------------------------------------------------------------
interface window_generator_7x7_if #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7
);
    logic [PIX_BIT-1:0]                       pix_in;
    logic                                     pix_valid;
    logic                                     sof;
    logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p;
    logic                                     win_valid;
    logic                                     frame_done;
    logic                                     overflow;

    modport master (
        output pix_in, pix_valid, sof,
        input  p, win_valid, frame_done, overflow
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output p, win_valid, frame_done, overflow
    );
endinterface

// File: rtl/window_generator_7x7.sv
// ---------------------------------------------------------------------------
// window_generator_7x7
//
// Purpose: turns a raster pixel stream into a sliding MASK_WIDTH x MASK_WIDTH
// window for the filter fabric. MASK_WIDTH-1 line buffers hold the previous
// lines; a shift register holds the window. Only windows with full support
// (no border padding) are flagged valid.
//
// Ports:
//   clk       system clock, rising edge
//   reset_in  asynchronous, active-low reset
//   bus       window_generator_7x7_if.slave
//               in : pix_in, pix_valid, sof
//               out: p, win_valid, frame_done, overflow
//
// Timing: a pixel accepted at edge N produces its window on p together with
// win_valid after edge N+1. The line-buffer read is registered at edge N and
// consumed at edge N+1, which is where that extra cycle goes.
// ---------------------------------------------------------------------------
module window_generator_7x7 #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   reset_in,
    window_generator_7x7_if.slave  bus
);

    localparam int LB = MASK_WIDTH - 1;        // number of line buffers
    localparam int CW = $clog2(IMG_WIDTH);     // column counter / RAM address
    localparam int RW = $clog2(IMG_HEIGHT);    // row counter
    localparam int RB = MASK_WIDTH * PIX_BIT;  // bits in one window row

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            overflow_q;

    logic            start;
    logic            accept;
    logic            last;
    logic            full_support;
    logic [CW-1:0]   cur_col;
    logic [RW-1:0]   cur_row;

    // Stage p0: pixel accepted, line-buffer read in flight
    logic                vld_p0;
    logic                win_p0;
    logic                last_p0;
    logic [PIX_BIT-1:0]  pix_p0;
    logic [CW-1:0]       col_p0;
    logic [LB*PIX_BIT-1:0] rd_p0;   // slice k = registered read of line buffer k

    // Stage p1: window register and registered outputs
    logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p_p1;
    logic                                     vld_p1;
    logic                                     done_p1;

    logic [RB-1:0]   col_vec;       // new window column, slice r = window row r

    // A sof pixel is always pixel (0,0), regardless of the counters' state.
    assign start        = bus.pix_valid && bus.sof;
    assign accept       = start || (bus.pix_valid && (state == ACTIVE));
    assign cur_col      = start ? '0 : col;
    assign cur_row      = start ? '0 : row;
    assign last         = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
    assign full_support = (cur_row >= RW'(MASK_WIDTH - 1)) && (cur_col >= CW'(MASK_WIDTH - 1));

    // Frame control: state, raster counters, overflow flag
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    state <= DONE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    state <= ACTIVE;
                    if (cur_col == CW'(IMG_WIDTH - 1)) begin
                        col <= '0;
                        row <= cur_row + 1'b1;
                    end else begin
                        col <= cur_col + 1'b1;
                        row <= cur_row;
                    end
                end
            end
            if (start) begin
                overflow_q <= 1'b0;
            end else if (bus.pix_valid && (state == DONE)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Stage p0 control: a reset drops any pixel still in flight
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            vld_p0  <= 1'b0;
            win_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= accept;
            win_p0  <= accept && full_support;
            last_p0 <= accept && last;
        end
    end

    // Stage p0 data
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_p0 <= bus.pix_in;
            col_p0 <= cur_col;
        end
    end

    // Line buffers: buffer k holds the line k+1 above the incoming one.
    // Read at edge N for the accepted pixel's column; the write-back of the
    // shifted column happens at edge N+1 to the same address, so the read
    // always sees the value from before this pixel.
    for (genvar k = 0; k < LB; k++) begin : g_lb
        logic [PIX_BIT-1:0] mem [IMG_WIDTH];
        logic [PIX_BIT-1:0] rd_q;
        logic [PIX_BIT-1:0] wr_d;

        if (k == 0) begin : g_first
            assign wr_d = pix_p0;
        end else begin : g_next
            assign wr_d = rd_p0[(k-1)*PIX_BIT +: PIX_BIT];
        end

        always_ff @(posedge clk) begin
            if (accept) begin
                rd_q <= mem[cur_col];
            end
            if (vld_p0) begin
                mem[col_p0] <= wr_d;
            end
        end

        assign rd_p0[k*PIX_BIT +: PIX_BIT] = rd_q;
    end

    // Column vector: bottom row is the new pixel, the row above it comes
    // from line buffer 0, the top row from the oldest line buffer.
    assign col_vec[(MASK_WIDTH-1)*PIX_BIT +: PIX_BIT] = pix_p0;
    for (genvar r = 0; r < MASK_WIDTH - 1; r++) begin : g_col
        assign col_vec[r*PIX_BIT +: PIX_BIT] = rd_p0[(MASK_WIDTH-2-r)*PIX_BIT +: PIX_BIT];
    end

    // Stage p1: shift window left by one column, insert new column at the right
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            p_p1    <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= win_p0;
            done_p1 <= last_p0;
            if (vld_p0) begin
                for (int r = 0; r < MASK_WIDTH; r++) begin
                    p_p1[r*RB +: RB] <= {col_vec[r*PIX_BIT +: PIX_BIT],
                                         p_p1[r*RB + PIX_BIT +: RB - PIX_BIT]};
                end
            end
        end
    end

    assign bus.p          = p_p1;
    assign bus.win_valid  = vld_p1;
    assign bus.frame_done = done_p1;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_window_generator_7x7.sv
// ---------------------------------------------------------------------------
// tb_window_generator_7x7
//
// Purpose: self-checking bench for window_generator_7x7 on a 10x8 image.
// A frame-level reference model stores the accepted image and cuts the
// expected window straight out of it.
// ---------------------------------------------------------------------------
module tb_window_generator_7x7;

    localparam int PIX_BIT    = 8;
    localparam int MASK_WIDTH = 7;
    localparam int IMG_WIDTH  = 10;
    localparam int IMG_HEIGHT = 8;
    localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW         = PIX_BIT * MASK_WIDTH * MASK_WIDTH;

    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    window_generator_7x7_if #(.PIX_BIT(PIX_BIT), .MASK_WIDTH(MASK_WIDTH)) bus ();

    window_generator_7x7 #(
        .PIX_BIT   (PIX_BIT),
        .MASK_WIDTH(MASK_WIDTH),
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) dut (
        .clk     (clk),
        .reset_in(reset_in),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: m_n is the index of the next raster pixel of the
    // frame (-1 = no frame yet, NPIX = frame complete).
    int           m_n;
    logic         m_ov;
    logic [7:0]   img [IMG_HEIGHT][IMG_WIDTH];
    logic         pend_wv, pend_fd;
    logic [PW-1:0] pend_p;
    logic         exp_wv, exp_fd;
    logic [PW-1:0] exp_p;
    logic         obs_wv, obs_fd, obs_ov;
    logic [PW-1:0] obs_p;
    logic [PW-1:0] win_ref [8];

    function automatic logic [7:0] sl(input logic [PW-1:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    function automatic logic [7:0] pv(input int n, input int off);
        return 8'((((n / IMG_WIDTH) << 4) | (n % IMG_WIDTH)) + off);
    endfunction

    task automatic model_reset();
        m_n     = -1;
        m_ov    = 1'b0;
        pend_wv = 1'b0;
        pend_fd = 1'b0;
        pend_p  = '0;
    endtask

    // Drive one cycle, advance the model on the edge, sample outputs #1 later.
    // exp_* afterwards describes what the DUT must show right now.
    task automatic step(input logic v, input logic s, input logic [7:0] px);
        logic          nwv, nfd;
        logic [PW-1:0] np;
        int            r, c;
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = px;
        @(posedge clk);
        nwv = 1'b0;
        nfd = 1'b0;
        np  = pend_p;
        if (v && s) begin
            m_n  = 0;
            m_ov = 1'b0;
        end
        if (v && m_n >= 0 && m_n < NPIX) begin
            r = m_n / IMG_WIDTH;
            c = m_n % IMG_WIDTH;
            img[r][c] = px;
            if (r >= MASK_WIDTH - 1 && c >= MASK_WIDTH - 1) begin
                nwv = 1'b1;
                for (int i = 0; i < MASK_WIDTH; i++)
                    for (int j = 0; j < MASK_WIDTH; j++)
                        np[8*(i*MASK_WIDTH+j) +: 8] = img[r-MASK_WIDTH+1+i][c-MASK_WIDTH+1+j];
            end
            nfd = (m_n == NPIX - 1);
            m_n++;
        end else if (v && m_n == NPIX) begin
            m_ov = 1'b1;
        end
        #1;
        obs_wv  = bus.win_valid;
        obs_fd  = bus.frame_done;
        obs_ov  = bus.overflow;
        obs_p   = bus.p;
        exp_wv  = pend_wv;
        exp_fd  = pend_fd;
        exp_p   = pend_p;
        pend_wv = nwv;
        pend_fd = nfd;
        pend_p  = np;
    endtask

    task automatic test_reset();
        reset_in      = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.p !== '0) begin errors++; $display("FAIL reset_p got %h want 0", bus.p); end
        checks++; if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b want 0", bus.win_valid); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        reset_in = 1'b1;
        // Pixels without sof in IDLE are ignored
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            checks++;
            if (obs_wv !== 1'b0 || obs_fd !== 1'b0) begin
                errors++; $display("FAIL idle_ignore wv=%b fd=%b want 0 0", obs_wv, obs_fd);
            end
        end
    endtask

    task automatic test_first_frame();
        int wins = 0;
        int fds  = 0;
        for (int n = 0; n <= NPIX; n++) begin
            if (n < NPIX) step(1'b1, n == 0, pv(n, 0));
            else          step(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_wv !== exp_wv || obs_fd !== exp_fd || (exp_wv && obs_p !== exp_p)) begin
                errors++;
                $display("FAIL frame1 n=%0d wv=%b fd=%b p=%h want wv=%b fd=%b p=%h", n, obs_wv, obs_fd, obs_p, exp_wv, exp_fd, exp_p);
            end
            if (exp_wv && wins < 8) win_ref[wins] = exp_p;
            if (obs_wv === 1'b1) wins++;
            if (obs_fd === 1'b1) fds++;
            if (n == 66) begin
                checks++; if (obs_wv !== 1'b0) begin errors++; $display("FAIL first_win_early got wv=%b want 0", obs_wv); end
            end
            if (n == 67) begin
                checks++;
                if (obs_wv !== 1'b1 || sl(obs_p, 0) !== 8'h00 || sl(obs_p, 24) !== 8'h33 || sl(obs_p, 48) !== 8'h66) begin
                    errors++;
                    $display("FAIL first_win got wv=%b s0=%h s24=%h s48=%h want 1 00 33 66", obs_wv, sl(obs_p, 0), sl(obs_p, 24), sl(obs_p, 48));
                end
            end
            if (n == NPIX) begin
                checks++;
                if (obs_wv !== 1'b1 || obs_fd !== 1'b1 || sl(obs_p, 0) !== 8'h13 || sl(obs_p, 48) !== 8'h79) begin
                    errors++;
                    $display("FAIL last_win got wv=%b fd=%b s0=%h s48=%h want 1 1 13 79", obs_wv, obs_fd, sl(obs_p, 0), sl(obs_p, 48));
                end
            end
        end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (obs_fd !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", obs_fd); end
        checks++; if (wins !== 8) begin errors++; $display("FAIL win_count got %0d want 8", wins); end
        checks++; if (fds !== 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fds); end
    endtask

    task automatic test_gaps();
        int   n      = 0;
        int   wins   = 0;
        logic prev_v = 1'b1;
        logic v;
        for (int cyc = 0; cyc < 1000 && n < NPIX; cyc++) begin
            v = 1'($urandom % 2);
            step(v, v && (n == 0), pv(n, 0));
            if (v) n++;
            checks++;
            if (obs_wv !== exp_wv || obs_fd !== exp_fd || (!prev_v && obs_wv !== 1'b0)) begin
                errors++;
                $display("FAIL gaps cyc=%0d wv=%b fd=%b want wv=%b fd=%b prev_valid=%b", cyc, obs_wv, obs_fd, exp_wv, exp_fd, prev_v);
            end
            if (obs_wv === 1'b1) begin
                checks++;
                if (wins >= 8 || obs_p !== win_ref[wins]) begin
                    errors++;
                    $display("FAIL gaps_window idx=%0d got %h want %h", wins, obs_p, win_ref[wins % 8]);
                end
                wins++;
            end
            prev_v = v;
        end
        checks++; if (n !== NPIX) begin errors++; $display("FAIL gaps_budget got %0d pixels want %0d", n, NPIX); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (obs_wv === 1'b1) begin
                checks++;
                if (wins >= 8 || obs_p !== win_ref[wins]) begin
                    errors++; $display("FAIL gaps_window idx=%0d got %h want %h", wins, obs_p, win_ref[wins % 8]);
                end
                wins++;
            end
        end
        checks++; if (wins !== 8) begin errors++; $display("FAIL gaps_win_count got %0d want 8", wins); end
    endtask

    task automatic test_overflow();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", bus.overflow); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'hFF);
            checks++;
            if (obs_wv !== 1'b0 || obs_ov !== 1'b1 || obs_ov !== m_ov) begin
                errors++; $display("FAIL ovf_extra i=%0d wv=%b ov=%b want 0 1", i, obs_wv, obs_ov);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (obs_ov !== 1'b1 || obs_wv !== 1'b0) begin errors++; $display("FAIL ovf_sticky ov=%b wv=%b want 1 0", obs_ov, obs_wv); end
        for (int n = 0; n <= NPIX; n++) begin
            if (n < NPIX) step(1'b1, n == 0, pv(n, 0));
            else          step(1'b0, 1'b0, 8'h00);
            if (n == 0) begin
                checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", obs_ov); end
            end
            checks++;
            if (obs_wv !== exp_wv || obs_fd !== exp_fd || (exp_wv && obs_p !== exp_p)) begin
                errors++;
                $display("FAIL ovf_frame n=%0d wv=%b fd=%b p=%h want wv=%b fd=%b p=%h", n, obs_wv, obs_fd, obs_p, exp_wv, exp_fd, exp_p);
            end
            if (n == 67) begin
                checks++;
                if (obs_wv !== 1'b1 || sl(obs_p, 0) !== 8'h00 || sl(obs_p, 24) !== 8'h33 || sl(obs_p, 48) !== 8'h66) begin
                    errors++;
                    $display("FAIL ovf_first_win wv=%b s0=%h s24=%h s48=%h want 1 00 33 66", obs_wv, sl(obs_p, 0), sl(obs_p, 24), sl(obs_p, 48));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int n = 0; n < 43; n++) step(1'b1, n == 0, pv(n, 0));
        reset_in = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.p !== '0) begin errors++; $display("FAIL midreset_p got %h want 0", bus.p); end
        checks++; if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL midreset_wv got %b want 0", bus.win_valid); end
        @(posedge clk);
        #1;
        reset_in = 1'b1;
        for (int n = 0; n <= NPIX; n++) begin
            if (n < NPIX) step(1'b1, n == 0, pv(n, 1));
            else          step(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_wv !== exp_wv || obs_fd !== exp_fd || (exp_wv && obs_p !== exp_p)) begin
                errors++;
                $display("FAIL midreset_frame n=%0d wv=%b fd=%b p=%h want wv=%b fd=%b p=%h", n, obs_wv, obs_fd, obs_p, exp_wv, exp_fd, exp_p);
            end
            if (n == 67) begin
                checks++;
                if (obs_wv !== 1'b1 || sl(obs_p, 24) !== 8'h34 || sl(obs_p, 0) !== 8'h01) begin
                    errors++; $display("FAIL midreset_first_win wv=%b s0=%h s24=%h want 1 01 34", obs_wv, sl(obs_p, 0), sl(obs_p, 24));
                end
            end
        end
    endtask

    task automatic test_sof_restart();
        int wins = 0;
        for (int n = 0; n < 63; n++) begin
            step(1'b1, n == 0, pv(n, 0));
            if (obs_wv === 1'b1) wins++;
        end
        for (int n = 0; n <= NPIX; n++) begin
            if (n < NPIX) step(1'b1, n == 0, pv(n, 8'h80));
            else          step(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_wv !== exp_wv || obs_fd !== exp_fd || (exp_wv && obs_p !== exp_p)) begin
                errors++;
                $display("FAIL restart_frame n=%0d wv=%b fd=%b p=%h want wv=%b fd=%b p=%h", n, obs_wv, obs_fd, obs_p, exp_wv, exp_fd, exp_p);
            end
            if (n < 67 && obs_wv === 1'b1) wins++;
            if (n == 67) begin
                checks++;
                if (obs_wv !== 1'b1 || sl(obs_p, 0) !== 8'h80 || sl(obs_p, 48) !== 8'hE6) begin
                    errors++; $display("FAIL restart_first_win wv=%b s0=%h s48=%h want 1 80 e6", obs_wv, sl(obs_p, 0), sl(obs_p, 48));
                end
            end
        end
        checks++; if (wins !== 0) begin errors++; $display("FAIL restart_early_windows got %0d want 0", wins); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_gaps();
        test_overflow();
        test_reset_midframe();
        test_sof_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
